game_flow_ctrl: RTL

//  Parametrised round/lives sequencer for the maze game. It replaces the fixed two-ghost init/game/resume/over logic in the top level.
//  - Compares the pacman tile against NUM_GHOSTS ghost tiles.
//  - Runs a frightened (power-pill) window.
//  - Counts lives and sequences the resume delay.
//  - Drives the reset/enable strobes for the sprite, map-writer and ghost-AI blocks.

---
 rtl/game_flow_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
//
// Round and lives sequencer for the maze game. It compares pacman's next tile
// against NUM_GHOSTS ghost tiles, runs the frightened (power-pill) window,
// counts lives, times the pause after a death, and drives the reset/enable
// strobes for the sprite controllers, the map RAM writer and the ghost AI.
// Every output is registered, so each output changes one clock after its cause.
//
// Optional feature: define EXTRA_LIFE_EN to award one extra life for every
// EXTRA_LIFE_AT ghosts eaten. Lives saturate at 7. Without the macro, no
// eaten-ghost counter is built and lives only ever go down.
//
// Ports
//   CLOCK_50      in   system clock
//   reset_n       in   asynchronous reset, active low
//   start         in   level; leaves INIT, and its rising edge leaves OVER/CLEAR
//   pac_x/pac_y   in   pacman next tile
//   ghost_x/_y    in   ghost next tiles, ghost i at [i*W +: W]
//   power_pill    in   one-cycle pulse when a power pill is eaten
//   pills_left_z  in   level; no pills remain on the level
//   sprite_reset  out  holds the sprite controllers in reset
//   map_wr_reset  out  holds the map RAM writer in reset
//   ghost_enable  out  lets the ghost AI run
//   frightened    out  frightened window is active
//   ghost_eaten   out  one-cycle pulse per ghost eaten
//   death         out  one-cycle pulse when a life is lost
//   lives         out  lives remaining
//   state         out  0 INIT, 1 PLAY, 2 DYING, 3 OVER, 4 CLEAR
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int NUM_GHOSTS    = 4,
    parameter int X_W           = 6,
    parameter int Y_W           = 5,
    parameter int LIVES_INIT    = 3,
    parameter int RESUME_CYCLES = 250000000,
    parameter int FRIGHT_CYCLES = 300000000,
    parameter int EXTRA_LIFE_AT = 8
) (
    input  logic                      CLOCK_50,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [X_W-1:0]            pac_x,
    input  logic [Y_W-1:0]            pac_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    input  logic                      power_pill,
    input  logic                      pills_left_z,
    output logic                      sprite_reset,
    output logic                      map_wr_reset,
    output logic                      ghost_enable,
    output logic                      frightened,
    output logic [NUM_GHOSTS-1:0]     ghost_eaten,
    output logic                      death,
    output logic [2:0]                lives,
    output logic [2:0]                state
);

    localparam int RES_W = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;
    localparam int FR_W  = (FRIGHT_CYCLES > 1) ? $clog2(FRIGHT_CYCLES) : 1;
    localparam logic [2:0]       LIVES_INIT_V = 3'(LIVES_INIT);
    localparam logic [RES_W-1:0] RES_LOAD     = RES_W'(RESUME_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_LOAD      = FR_W'(FRIGHT_CYCLES - 1);

    // Reject parameter values that the logic below cannot handle.
    generate
        if (NUM_GHOSTS < 1 || NUM_GHOSTS > 8) begin : g_bad_num_ghosts
            $error("game_flow_ctrl: NUM_GHOSTS must be 1..8");
        end
        if (LIVES_INIT < 1 || LIVES_INIT > 7) begin : g_bad_lives_init
            $error("game_flow_ctrl: LIVES_INIT must be 1..7");
        end
        if (EXTRA_LIFE_AT < 1) begin : g_bad_extra_life_at
            $error("game_flow_ctrl: EXTRA_LIFE_AT must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_OVER  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t                 state_reg;
    logic [2:0]             lives_reg;
    logic [RES_W-1:0]       resume_cnt_reg;
    logic [FR_W-1:0]        fright_cnt_reg;
    logic                   frightened_reg;
    logic [NUM_GHOSTS-1:0]  ghost_eaten_reg;
    logic                   death_reg;
    logic [NUM_GHOSTS-1:0]  hit_prev_reg;
    logic                   start_prev_reg;
    logic                   sprite_reset_reg;
    logic                   map_wr_reset_reg;
    logic                   ghost_enable_reg;

    logic [NUM_GHOSTS-1:0]  hit;
    logic [NUM_GHOSTS-1:0]  eat_mask;
    logic                   lethal;
    logic                   start_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GHOSTS; gi++) begin : g_hit
            assign hit[gi] = (ghost_x[gi*X_W +: X_W] == pac_x) &&
                             (ghost_y[gi*Y_W +: Y_W] == pac_y);
        end
    endgenerate

    // Collisions use the frightened value already in the register. A pill
    // eaten in this cycle therefore protects pacman only from the next cycle.
    assign lethal     = (|hit) && !frightened_reg;
    // A ghost that stays on pacman's tile is eaten once, not on every cycle.
    assign eat_mask   = frightened_reg ? (hit & ~hit_prev_reg) : '0;
    assign start_rise = start && !start_prev_reg;

`ifdef EXTRA_LIFE_EN
    localparam int EAT_W = $clog2(EXTRA_LIFE_AT + NUM_GHOSTS + 1);

    logic [EAT_W-1:0] eat_cnt_reg;
    logic [EAT_W-1:0] eat_sum;
    logic             bonus;

    function automatic logic [3:0] popcount(input logic [NUM_GHOSTS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        eat_sum = eat_cnt_reg + EAT_W'(popcount(ghost_eaten_reg));
        bonus   = (eat_sum >= EAT_W'(EXTRA_LIFE_AT));
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            eat_cnt_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            eat_cnt_reg <= '0;
        end else if (bonus) begin
            eat_cnt_reg <= eat_sum - EAT_W'(EXTRA_LIFE_AT);
        end else begin
            eat_cnt_reg <= eat_sum;
        end
    end
`endif

    // Adds the bonus life, if one is due this cycle, to a lives value that
    // already includes any death in the same cycle. Lives saturate at 7.
    function automatic logic [2:0] apply_bonus(input logic [2:0] l);
`ifdef EXTRA_LIFE_EN
        if (bonus && (l != 3'd7)) begin
            return l + 3'd1;
        end
`endif
        return l;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_INIT;
            lives_reg        <= LIVES_INIT_V;
            resume_cnt_reg   <= '0;
            fright_cnt_reg   <= '0;
            frightened_reg   <= 1'b0;
            ghost_eaten_reg  <= '0;
            death_reg        <= 1'b0;
            hit_prev_reg     <= '0;
            start_prev_reg   <= 1'b0;
            sprite_reset_reg <= 1'b1;
            map_wr_reset_reg <= 1'b1;
            ghost_enable_reg <= 1'b0;
        end else begin
            hit_prev_reg    <= hit;
            start_prev_reg  <= start;
            death_reg       <= 1'b0;
            ghost_eaten_reg <= '0;
            lives_reg       <= apply_bonus(lives_reg);

            // The frightened window runs down on its own; a pill or a death
            // in PLAY overrides this below.
            if (frightened_reg) begin
                if (fright_cnt_reg == '0) begin
                    frightened_reg <= 1'b0;
                end else begin
                    fright_cnt_reg <= fright_cnt_reg - 1'b1;
                end
            end

            case (state_reg)
                ST_INIT: begin
                    lives_reg      <= LIVES_INIT_V;
                    frightened_reg <= 1'b0;
                    fright_cnt_reg <= '0;
                    if (start) begin
                        state_reg        <= ST_PLAY;
                        sprite_reset_reg <= 1'b0;
                        map_wr_reset_reg <= 1'b0;
                        ghost_enable_reg <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (lethal) begin
                        // Any number of lethal ghosts in one cycle cost one life.
                        death_reg        <= 1'b1;
                        frightened_reg   <= 1'b0;
                        fright_cnt_reg   <= '0;
                        ghost_enable_reg <= 1'b0;
                        if (lives_reg > 3'd1) begin
                            state_reg        <= ST_DYING;
                            lives_reg        <= apply_bonus(lives_reg - 3'd1);
                            resume_cnt_reg   <= RES_LOAD;
                            sprite_reset_reg <= 1'b1;
                        end else begin
                            state_reg        <= ST_OVER;
                            lives_reg        <= apply_bonus(3'd0);
                            map_wr_reset_reg <= 1'b1;
                        end
                    end else begin
                        ghost_eaten_reg <= eat_mask;
                        // A repeat pill restarts the window from full length.
                        if (power_pill) begin
                            frightened_reg <= 1'b1;
                            fright_cnt_reg <= FR_LOAD;
                        end
                        if (pills_left_z) begin
                            state_reg        <= ST_CLEAR;
                            map_wr_reset_reg <= 1'b1;
                            ghost_enable_reg <= 1'b0;
                        end
                    end
                end

                ST_DYING: begin
                    if (resume_cnt_reg == '0) begin
                        state_reg        <= ST_PLAY;
                        sprite_reset_reg <= 1'b0;
                        map_wr_reset_reg <= 1'b0;
                        ghost_enable_reg <= 1'b1;
                    end else begin
                        resume_cnt_reg <= resume_cnt_reg - 1'b1;
                    end
                end

                ST_OVER, ST_CLEAR: begin
                    // A start level left high from the previous round must be
                    // released and pressed again.
                    if (start_rise) begin
                        state_reg        <= ST_INIT;
                        lives_reg        <= LIVES_INIT_V;
                        sprite_reset_reg <= 1'b1;
                        map_wr_reset_reg <= 1'b1;
                        ghost_enable_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg        <= ST_INIT;
                    lives_reg        <= LIVES_INIT_V;
                    sprite_reset_reg <= 1'b1;
                    map_wr_reset_reg <= 1'b1;
                    ghost_enable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign state        = state_reg;
    assign lives        = lives_reg;
    assign frightened   = frightened_reg;
    assign ghost_eaten  = ghost_eaten_reg;
    assign death        = death_reg;
    assign sprite_reset = sprite_reset_reg;
    assign map_wr_reset = map_wr_reset_reg;
    assign ghost_enable = ghost_enable_reg;

endmodule
